// File: rtl/parking_gate_arbiter_if.sv
// rtl/parking_gate_arbiter_if.sv - sensor request and gate status bundle for parking_gate_arbiter
interface parking_gate_arbiter_if #(
    parameter int N_SLOTS = 4,
    parameter int SLOT_W  = 2,
    parameter int CAP_W   = 3
);
    logic               tick;
    logic               entry_sensor;
    logic               exit_sensor;
    logic [SLOT_W-1:0]  exit_slot;
    logic [N_SLOTS-1:0] parking_slots;
    logic               door_open;
    logic               full_light;
    logic [CAP_W-1:0]   capacity;
    logic [SLOT_W-1:0]  grant_slot;
    logic               grant_valid;
    logic               reject;

    modport master (
        output tick, entry_sensor, exit_sensor, exit_slot,
        input  parking_slots, door_open, full_light, capacity,
               grant_slot, grant_valid, reject
    );

    modport slave (
        input  tick, entry_sensor, exit_sensor, exit_slot,
        output parking_slots, door_open, full_light, capacity,
               grant_slot, grant_valid, reject
    );
endinterface

// File: rtl/parking_gate_arbiter.sv
// rtl/parking_gate_arbiter.sv - one-car-at-a-time gate sequencer with slot allocation
// Optional round-robin entry/exit arbitration under PARK_RR_ARB_EN.
module parking_gate_arbiter #(
    parameter int N_SLOTS    = 4,
    parameter int SLOT_W     = 2,
    parameter int CAP_W      = 3,
    parameter int DOOR_TICKS = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    parking_gate_arbiter_if.slave    bus
);
    localparam int TCNT_W = $clog2(DOOR_TICKS + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OPEN = 1'b1;

    logic [0:0]         state;
    logic               entry_prev;
    logic               exit_prev;
    logic               entry_pend;
    logic               exit_pend;
    logic [SLOT_W-1:0]  exit_slot_q;
    logic [N_SLOTS-1:0] slots;
    logic [TCNT_W-1:0]  tick_cnt;
    logic               door_q;
    logic               grant_valid_q;
    logic               reject_q;
    logic [SLOT_W-1:0]  grant_slot_q;

    logic               entry_rise;
    logic               exit_rise;
    logic               serve_exit;
    logic               serve_entry;
    logic               entry_clr;
    logic               exit_clr;
    logic               full;
    logic [SLOT_W-1:0]  free_idx;
    logic [CAP_W-1:0]   used_cnt;

`ifdef PARK_RR_ARB_EN
    logic               prio_exit;
`endif

    assign entry_rise = bus.entry_sensor & ~entry_prev;
    assign exit_rise  = bus.exit_sensor & ~exit_prev;
    assign full       = &slots;

`ifdef PARK_RR_ARB_EN
    assign serve_exit = exit_pend & (~entry_pend | prio_exit);
`else
    assign serve_exit = exit_pend;
`endif
    assign serve_entry = entry_pend & ~serve_exit;
    assign entry_clr   = (state == ST_IDLE) & serve_entry;
    assign exit_clr    = (state == ST_IDLE) & serve_exit;

    // Scan from the top so the last assignment leaves the lowest free index.
    always_comb begin
        free_idx = '0;
        used_cnt = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (!slots[i]) begin
                free_idx = SLOT_W'(i);
            end
        end
        for (int i = 0; i < N_SLOTS; i++) begin
            used_cnt = used_cnt + CAP_W'(slots[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            entry_prev    <= 1'b0;
            exit_prev     <= 1'b0;
            entry_pend    <= 1'b0;
            exit_pend     <= 1'b0;
            exit_slot_q   <= '0;
            slots         <= '0;
            tick_cnt      <= '0;
            door_q        <= 1'b0;
            grant_valid_q <= 1'b0;
            reject_q      <= 1'b0;
            grant_slot_q  <= '0;
`ifdef PARK_RR_ARB_EN
            prio_exit     <= 1'b1;
`endif
        end else begin
            grant_valid_q <= 1'b0;
            reject_q      <= 1'b0;
            entry_prev    <= bus.entry_sensor;
            exit_prev     <= bus.exit_sensor;

            // A fresh edge survives a same-cycle clear; a repeat edge while pending merges.
            entry_pend <= (entry_pend & ~entry_clr) | entry_rise;
            exit_pend  <= (exit_pend & ~exit_clr) | exit_rise;
            if (exit_rise && (!exit_pend || exit_clr)) begin
                exit_slot_q <= bus.exit_slot;
            end

            case (state)
                ST_IDLE: begin
                    if (serve_exit) begin
                        if (slots[exit_slot_q]) begin
                            slots[exit_slot_q] <= 1'b0;
                            grant_slot_q       <= exit_slot_q;
                            grant_valid_q      <= 1'b1;
                            door_q             <= 1'b1;
                            state              <= ST_OPEN;
                        end else begin
                            reject_q <= 1'b1;
                        end
                    end else if (serve_entry) begin
                        if (!full) begin
                            slots[free_idx] <= 1'b1;
                            grant_slot_q    <= free_idx;
                            grant_valid_q   <= 1'b1;
                            door_q          <= 1'b1;
                            state           <= ST_OPEN;
                        end else begin
                            reject_q <= 1'b1;
                        end
                    end
`ifdef PARK_RR_ARB_EN
                    if (entry_pend && exit_pend) begin
                        prio_exit <= ~prio_exit;
                    end
`endif
                end
                ST_OPEN: begin
                    if (bus.tick) begin
                        if (tick_cnt == TCNT_W'(DOOR_TICKS - 1)) begin
                            tick_cnt <= '0;
                            door_q   <= 1'b0;
                            state    <= ST_IDLE;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.parking_slots = slots;
    assign bus.door_open     = door_q;
    assign bus.full_light    = full;
    assign bus.capacity      = CAP_W'(N_SLOTS) - used_cnt;
    assign bus.grant_slot    = grant_slot_q;
    assign bus.grant_valid   = grant_valid_q;
    assign bus.reject        = reject_q;
endmodule
